// File: rtl/score_tally.sv
// score_tally: banks per-level scores into a saturating game total and converts it to BCD via double-dabble.
// Define HIGH_SCORE_EN to build the session high-score register; otherwise high_score is tied to zero.
module score_tally #(
    parameter int SCORE_W   = 10,
    parameter int TOTAL_W   = 14,
    parameter int MAX_SCORE = 9999
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic [1:0]         level,
    input  logic [SCORE_W-1:0] level_score,
    input  logic               level_won,
    input  logic               game_restart,
    output logic [TOTAL_W-1:0] total_bin,
    output logic [3:0]         bcd_thou,
    output logic [3:0]         bcd_hund,
    output logic [3:0]         bcd_tens,
    output logic [3:0]         bcd_ones,
    output logic               bcd_valid,
    output logic               busy,
    output logic [TOTAL_W-1:0] high_score
);
    localparam int SW = TOTAL_W + 16;
    localparam int CW = $clog2(TOTAL_W);
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
    state_t             state;
    logic [TOTAL_W:0]   sum;
    logic [TOTAL_W-1:0] disp_sum, banked, conv_src;
    logic [1:0]         level_q;
    logic               won_q, lvl_drop, bank;
    logic [SW-1:0]      sh, adj;
    logic [CW-1:0]      cnt;
    assign sum      = {1'b0, banked} + {{(TOTAL_W + 1 - SCORE_W){1'b0}}, level_score};
    assign disp_sum = (sum > (TOTAL_W + 1)'(MAX_SCORE)) ? TOTAL_W'(MAX_SCORE) : sum[TOTAL_W-1:0];
    // A level change without the won flag is a loss/restart path and must never bank.
    assign lvl_drop = (level != level_q) & ~level_won;
    assign bank     = level_won & ~won_q & ~game_restart & ~lvl_drop;
    always_comb begin
        adj = sh;
        for (int i = 0; i < 4; i++)
            adj[TOTAL_W+4*i +: 4] = (sh[TOTAL_W+4*i +: 4] >= 4'd5) ? sh[TOTAL_W+4*i +: 4] + 4'd3 : sh[TOTAL_W+4*i +: 4];
    end
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            banked    <= '0;
            total_bin <= '0;
            conv_src  <= '0;
            level_q   <= '0;
            won_q     <= 1'b0;
            sh        <= '0;
            cnt       <= '0;
            bcd_thou  <= '0;
            bcd_hund  <= '0;
            bcd_tens  <= '0;
            bcd_ones  <= '0;
            bcd_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            won_q     <= level_won;
            level_q   <= level;
            total_bin <= disp_sum;
            bcd_valid <= 1'b0;
            if (game_restart)
                banked <= '0;
            else if (bank)
                banked <= disp_sum;
            case (state)
                IDLE: if (disp_sum != conv_src) begin
                    state <= LOAD;
                    busy  <= 1'b1;
                end
                LOAD: begin
                    conv_src <= disp_sum;
                    sh       <= {16'b0, disp_sum};
                    cnt      <= '0;
                    state    <= SHIFT;
                end
                SHIFT: begin
                    sh  <= adj << 1;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(TOTAL_W - 1))
                        state <= DONE;
                end
                DONE: begin
                    bcd_thou  <= sh[TOTAL_W+12 +: 4];
                    bcd_hund  <= sh[TOTAL_W+8 +: 4];
                    bcd_tens  <= sh[TOTAL_W+4 +: 4];
                    bcd_ones  <= sh[TOTAL_W +: 4];
                    bcd_valid <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end
`ifdef HIGH_SCORE_EN
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            high_score <= '0;
        else if (game_restart && disp_sum > high_score)
            high_score <= disp_sum;
    end
`else
    assign high_score = '0;
`endif
endmodule
